sdram_module: RTL and testbench

Single-device, 256 x 8 synchronous memory with an SDRAM-style active-low strobe interface and a bidirectional 8-bit data bus. It accepts write, read and refresh commands, one per clock, decoded from independent strobes. It is the behavioural memory endpoint behind the team's SDRAM controller path, where a simple and predictable bus model is needed.

---
 rtl/sdram_module_if.sv | 26 ++
 rtl/sdram_module.sv | 86 ++++++++
 tb/tb_sdram_module.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sdram_module_if.sv
// sdram_module_if
// Purpose : command/address strobe bundle for the behavioural SDRAM memory.
// Signals : cs_n  - chip select (active low, no functional effect)
//           ras_n - refresh strobe (active low)
//           cas_n - read strobe (active low)
//           we_n  - write strobe (active low)
//           addr  - word address for read/write
// The bidirectional data bus is a separate inout port on the memory so the
// tristate driver lives directly at a module boundary.
interface sdram_module_if #(
  parameter int ADDR_W = 8
) ();
  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr;

  modport master (
    output cs_n, ras_n, cas_n, we_n, addr
  );

  modport slave (
    input cs_n, ras_n, cas_n, we_n, addr
  );
endinterface

// File: rtl/sdram_module.sv
// sdram_module
// Purpose : single-device 2**ADDR_W x DATA_W synchronous memory with an
//           SDRAM-style active-low strobe interface. One command per clock,
//           decoded by fixed priority REFRESH > WRITE > READ > NOP.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset (clears memory, bus, counter)
//           bus  - strobes and address (sdram_module_if.slave)
//           dq   - bidirectional data bus, driven only while read data is out
module sdram_module #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  sdram_module_if.slave      bus,
  inout  wire  [DATA_W-1:0]  dq
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_READ,
    CMD_WRITE,
    CMD_REFRESH
  } cmd_e;

  cmd_e              cmd;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] refresh_row_q, refresh_row_d;

  // Chip select is ignored: this model is always the selected device.
  wire unused_cs_n = bus.cs_n;

  // Strobe decode and next-state for the bus/refresh registers.
  always_comb begin
    cmd           = CMD_NOP;
    rd_data_d     = rd_data_q;
    oe_d          = 1'b0;
    refresh_row_d = refresh_row_q;
    if (!bus.ras_n) begin
      cmd = CMD_REFRESH;
    end else if (!bus.we_n) begin
      // A write with cas_n also low still clears oe, avoiding bus contention.
      cmd = CMD_WRITE;
    end else if (!bus.cas_n) begin
      cmd = CMD_READ;
    end
    case (cmd)
      CMD_REFRESH: refresh_row_d = refresh_row_q + ADDR_W'(1);
      CMD_READ: begin
        rd_data_d = mem_q[bus.addr];
        oe_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q     <= '0;
      oe_q          <= 1'b0;
      refresh_row_q <= '0;
    end else begin
      rd_data_q     <= rd_data_d;
      oe_q          <= oe_d;
      refresh_row_q <= refresh_row_d;
    end
  end

  // Storage is cleared by reset, so it is a register array rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (cmd == CMD_WRITE) begin
      mem_q[bus.addr] <= dq;
    end
  end

  assign dq = oe_q ? rd_data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_module.sv
module tb_sdram_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tb_drv;
  logic       tb_drv_en;
  wire  [7:0] dq;

  sdram_module_if #(.ADDR_W(8)) bus ();

  assign dq = tb_drv_en ? tb_drv : 8'hzz;

  sdram_module #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dq  (dq)
  );

  // Reference model: memory contents, refresh count and expected bus state.
  logic [7:0] m_mem [256];
  logic [7:0] m_row;
  logic       m_oe;
  logic [7:0] m_rd;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  task automatic check_bus(input string tag);
    checks++;
    assert (dut.oe_q === m_oe) else begin
      errors++;
      $error("FAIL %s oe: observed %b expected %b", tag, dut.oe_q, m_oe);
    end
    if (m_oe) begin
      checks++;
      assert (dq === m_rd) else begin
        errors++;
        $error("FAIL %s dq: observed %h expected %h", tag, dq, m_rd);
      end
    end
  endtask

  task automatic check_row(input string tag);
    checks++;
    assert (dut.refresh_row_q === m_row) else begin
      errors++;
      $error("FAIL %s refresh_row: observed %h expected %h", tag, dut.refresh_row_q, m_row);
    end
  endtask

  // One clock of stimulus, model update, then a check 1 time unit after the edge.
  task automatic apply(input logic r, input logic ras, input logic cas, input logic we,
                       input logic cs, input logic [7:0] a, input logic den,
                       input logic [7:0] dv, input string tag);
    string cmd_s;
    @(negedge clk);
    rst = r; bus.ras_n = ras; bus.cas_n = cas; bus.we_n = we; bus.cs_n = cs;
    bus.addr = a; tb_drv_en = den; tb_drv = dv;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_row = 8'h00; m_oe = 1'b0; m_rd = 8'h00; cmd_s = "RESET";
    end else if (!ras) begin
      m_row = m_row + 8'h01; m_oe = 1'b0; cmd_s = "REFRESH";
    end else if (!we) begin
      m_mem[a] = dv; m_oe = 1'b0; cmd_s = "WRITE";
    end else if (!cas) begin
      m_rd = m_mem[a]; m_oe = 1'b1; cmd_s = "READ";
    end else begin
      m_oe = 1'b0; cmd_s = "NOP";
    end
    #1;
    step_no++;
    $display("step %0d %s %s addr=%h wdata=%h oe=%b dq=%h", step_no, tag, cmd_s, a,
             dv, dut.oe_q, dq);
    check_bus(tag);
  endtask

  // Wrapper: if the testbench wants to drive dq while read data is still out,
  // insert an idle cycle first so the bus turns around cleanly.
  task automatic step(input logic r, input logic ras, input logic cas, input logic we,
                      input logic cs, input logic [7:0] a, input logic den,
                      input logic [7:0] dv, input string tag);
    if (den && m_oe && !r) apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a, 1'b0, 8'h00, "turn");
    apply(r, ras, cas, we, cs, a, den, dv, tag);
  endtask

  initial begin
    rst = 1'b1; bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1; bus.cs_n = 1'b1;
    bus.addr = 8'h00; tb_drv_en = 1'b0; tb_drv = 8'h00;
    m_row = 8'h00; m_oe = 1'b0; m_rd = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hxx;

    // Reset, then idle cycles keep the bus released.
    step(1, 1, 1, 1, 1, 8'h00, 0, 8'h00, "rst");
    step(1, 1, 1, 1, 1, 8'h00, 0, 8'h00, "rst");
    check_row("reset");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 8'h00, 0, 8'h00, "idle");
    step(0, 1, 0, 1, 0, 8'h5A, 0, 8'h00, "rd_after_rst");

    // Single write then a 2-cycle read of the same word.
    step(0, 1, 1, 0, 0, 8'h01, 1, 8'hA5, "wr01");
    step(0, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rd01a");
    step(0, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rd01b");

    // Boundary addresses, back-to-back reads.
    step(0, 1, 1, 0, 0, 8'h00, 1, 8'h3C, "wr00");
    step(0, 1, 1, 0, 0, 8'hFF, 1, 8'hC3, "wrFF");
    step(0, 1, 0, 1, 0, 8'hFF, 0, 8'h00, "rdFF");
    step(0, 1, 0, 1, 0, 8'h00, 0, 8'h00, "rd00");
    step(0, 1, 1, 1, 1, 8'h00, 0, 8'h00, "release");

    // 256 refreshes with a write attempt on every cycle: writes dropped, row wraps.
    for (int i = 0; i < 256; i++) step(0, 0, 1, 0, 0, 8'h01, 1, 8'h55, "refresh");
    check_row("refresh_wrap");
    step(0, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rd01_after_ref");

    // Write and read strobes together: write wins, bus not driven.
    step(0, 1, 0, 0, 0, 8'h10, 1, 8'h77, "wr_rd_same");
    step(0, 1, 0, 1, 0, 8'h10, 0, 8'h00, "rd10");

    // Randomised traffic with occasional reset and random chip select.
    for (int i = 0; i < 400; i++) begin
      logic r, ras, cas, we, cs;
      logic [7:0] a;
      r   = ($urandom_range(0, 59) == 0);
      ras = ($urandom_range(0, 7) != 0);
      cas = $urandom_range(0, 1) != 0;
      we  = $urandom_range(0, 1) != 0;
      cs  = $urandom_range(0, 1) != 0;
      a   = 8'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
      step(r, ras, cas, we, cs, a, !we, 8'($urandom), "rand");
    end
    check_row("rand_row");

    // Reset during an active read, then the written word reads back as zero.
    step(0, 1, 1, 0, 0, 8'h01, 1, 8'hA5, "wr01_again");
    step(0, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rd_before_rst");
    step(1, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rst_mid_read");
    check_row("rst_mid_read");
    step(0, 1, 0, 1, 0, 8'h01, 0, 8'h00, "rd01_after_rst");
    step(0, 1, 1, 1, 1, 8'h00, 0, 8'h00, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
